fifo_param: RTL and testbench

Parametrised successor to the 8-bit pushbutton FIFO. Adds configurable width, depth and thresholds, on-chip synchronisation and edge detection of the active-low push/pop buttons, an occupancy count, almost-full/almost-empty flags, sticky overflow/underflow errors and a pop strobe. Sits between board switches/buttons and the bin2bcd → seven-segment display path; `pop_valid` drives bin2bcd `start`.

---
 rtl/fifo_param_pkg.sv | 22 ++
 rtl/fifo_param_if.sv | 38 +++
 rtl/fifo_param_mem.sv | 27 ++
 rtl/fifo_param.sv | 129 ++++++++++++
 tb/tb_fifo_param.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_param_pkg.sv
// Shared definitions for fifo_param: clog2 helper, default geometry and the
// reset value of the button conditioning flops.
package fifo_param_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Conditioning flops reset to the "pressed" level, so a button held low
  // through reset never produces a falling edge afterwards.
  localparam logic BTN_RST_VAL = 1'b0;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Button/data/status bundle of fifo_param. The slave modport is the FIFO,
// the master modport is whoever drives the buttons and data.
interface fifo_param_if
  import fifo_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CW = clog2_f(DEPTH) + 1;

  logic             push_n;
  logic             pop_n;
  logic             err_clr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             pop_valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push_n, pop_n, err_clr, din,
    input  dout, pop_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  push_n, pop_n, err_clr, din,
    output dout, pop_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_param_mem.sv
// DEPTH x WIDTH register file: synchronous write, asynchronous read.
module fifo_param_mem
  import fifo_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR  = clog2_f(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ADDR-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised pushbutton FIFO with button synchronisation/edge detection,
// occupancy count, almost flags, sticky errors and a pop strobe.
// Optional first-word-fall-through output: define FIFO_FWFT_EN.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic         clk,
  input  logic         reset,
  fifo_param_if.slave  bus
);

  localparam int ADDR = clog2_f(DEPTH);
  localparam int PW   = ADDR + 1;
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

  logic [2:0]       push_sync_q, push_sync_d;
  logic [2:0]       pop_sync_q, pop_sync_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             pop_valid_q, pop_valid_d;
  logic             push_tick, pop_tick;
  logic             push_ok, pop_ok;
  logic             full, empty;
  logic [PW-1:0]    count;
  logic [WIDTH-1:0] rd_data;

  // Button shift chains (bit0 = s1, bit2 = s3) and one tick per falling edge.
  always_comb begin
    push_sync_d = {push_sync_q[1:0], bus.push_n};
    pop_sync_d  = {pop_sync_q[1:0], bus.pop_n};
    push_tick   = push_sync_q[2] & ~push_sync_q[1];
    pop_tick    = pop_sync_q[2] & ~pop_sync_q[1];
  end

  // Status from the registered pointers and the commit/error decisions,
  // all judged against the pre-edge state.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count       = wr_ptr_q - rd_ptr_q;
    empty       = (wr_ptr_q == rd_ptr_q);
    full        = (wr_ptr_q[ADDR] != rd_ptr_q[ADDR]) &&
                  (wr_ptr_q[ADDR-1:0] == rd_ptr_q[ADDR-1:0]);
    // A push into a full FIFO still succeeds when a pop frees the head slot.
    push_ok     = push_tick & (~full | pop_tick);
    pop_ok      = pop_tick & ~empty;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    // An error event outranks a clear in the same cycle.
    overflow_d  = (overflow_q & ~bus.err_clr) | (push_tick & full & ~pop_tick);
    underflow_d = (underflow_q & ~bus.err_clr) | (pop_tick & empty);
    pop_valid_d = pop_ok;
  end

  // State registers, synchronous active-high reset.
  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_sync_q <= {3{BTN_RST_VAL}};
      pop_sync_q  <= {3{BTN_RST_VAL}};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      pop_valid_q <= 1'b0;
    end else begin
      push_sync_q <= push_sync_d;
      pop_sync_q  <= pop_sync_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  fifo_param_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR  (ADDR)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q[ADDR-1:0]),
    .wdata (bus.din),
    .raddr (rd_ptr_q[ADDR-1:0]),
    .rdata (rd_data)
  );

`ifdef FIFO_FWFT_EN
  // Head entry is always presented; zero when there is nothing to show.
  assign bus.dout = empty ? '0 : rd_data;
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  // Output register loads the head only on a successful pop.
  always_comb begin
    dout_d = dout_q;
    if (pop_ok) dout_d = rd_data;
  end

  // Output data register.
  always_ff @(posedge clk) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign bus.dout = dout_q;
`endif

  assign bus.pop_valid    = pop_valid_q;
  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= AFULL_C);
  assign bus.almost_empty = (count <= AEMPTY_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: table of button operations with
// expected occupancy/error flags, a data scoreboard checked on pop_valid,
// and hand-written reset sequences.
module tb_fifo_param;
  import fifo_param_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_TH  (DEPTH - 2),
    .AEMPTY_TH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit         push;
    bit         pop;
    bit         clr;
    logic [7:0] data;
    int         exp_count;
    bit         exp_ovf;
    bit         exp_unf;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] model_q[$];
  logic [7:0] exp_pop_q[$];
  logic [7:0] last_dout;
  logic [7:0] mon_exp;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input bit push, input bit pop, input bit clr,
                              input logic [7:0] data, input int c,
                              input bit o, input bit u);
    vec_t v;
    v.push = push; v.pop = pop; v.clr = clr; v.data = data;
    v.exp_count = c; v.exp_ovf = o; v.exp_unf = u;
    tbl.push_back(v);
  endfunction

  function automatic logic [7:0] exp_dout();
`ifdef FIFO_FWFT_EN
    return (model_q.size() > 0) ? model_q[0] : 8'h00;
`else
    return last_dout;
`endif
  endfunction

  // Scoreboard consumer: every pop_valid pulse must match a pending entry.
  always @(negedge clk) begin
    if (!reset && bus.pop_valid === 1'b1) begin
      if (exp_pop_q.size() == 0) begin
        check("pop_valid_unexpected", {31'd0, bus.pop_valid}, 32'd0);
      end else begin
        mon_exp = exp_pop_q.pop_front();
        check("pop_dout", {24'd0, bus.dout}, {24'd0, mon_exp});
      end
    end
  end

  task automatic check_idle(input int c, input bit o, input bit u);
    check("count", {27'd0, bus.count}, c);
    check("full", {31'd0, bus.full}, {31'd0, c == DEPTH});
    check("empty", {31'd0, bus.empty}, {31'd0, c == 0});
    check("almost_full", {31'd0, bus.almost_full}, {31'd0, c >= DEPTH - 2});
    check("almost_empty", {31'd0, bus.almost_empty}, {31'd0, c <= 2});
    check("overflow", {31'd0, bus.overflow}, {31'd0, o});
    check("underflow", {31'd0, bus.underflow}, {31'd0, u});
    check("pop_valid_missing", exp_pop_q.size(), 0);
    check("dout_idle", {24'd0, bus.dout}, {24'd0, exp_dout()});
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_pop_q.delete();
    last_dout = 8'h00;
  endtask

  // One button operation: press held 5 cycles, optional err_clr aligned
  // with the commit edge, then settle and compare.
  task automatic do_step(input vec_t v);
    int         pre;
    bit         q_ok, p_ok;
    logic [7:0] popped;
    pre    = model_q.size();
    popped = 8'h00;
    q_ok   = v.pop && (pre > 0);
    p_ok   = v.push && ((pre < DEPTH) || v.pop);
    if (q_ok) popped = model_q.pop_front();
    if (p_ok) model_q.push_back(v.data);
    if (q_ok) begin
      last_dout = popped;
`ifdef FIFO_FWFT_EN
      exp_pop_q.push_back(exp_dout());
`else
      exp_pop_q.push_back(popped);
`endif
    end
    @(negedge clk);
    bus.din    = v.data;
    bus.push_n = !v.push;
    bus.pop_n  = !v.pop;
    repeat (2) @(negedge clk);
    if (v.clr) bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    repeat (2) @(negedge clk);
    bus.push_n = 1'b1;
    bus.pop_n  = 1'b1;
    repeat (6) @(negedge clk);
    check_idle(v.exp_count, v.exp_ovf, v.exp_unf);
  endtask

  initial begin
    vec_t v;
    reset       = 1'b1;
    bus.push_n  = 1'b1;
    bus.pop_n   = 1'b1;
    bus.err_clr = 1'b0;
    bus.din     = 8'h00;
    model_reset();

    // Operation table: {push, pop, clr, data, count, overflow, underflow}.
    add(1, 0, 0, 8'h11, 1, 0, 0);
    add(1, 0, 0, 8'h22, 2, 0, 0);
    add(1, 0, 0, 8'h33, 3, 0, 0);
    add(0, 1, 0, 8'h00, 2, 0, 0);
    add(0, 1, 0, 8'h00, 1, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 1);
    add(0, 0, 1, 8'h00, 0, 0, 0);
    add(0, 1, 1, 8'h00, 0, 0, 1);
    add(0, 0, 1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(1, 0, 0, 8'(i), i + 1, 0, 0);
    add(1, 0, 0, 8'h99, 16, 1, 0);
    add(0, 0, 1, 8'h00, 16, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 8'h00, 15 - i, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 0, 0, 8'(8'h40 + i), 9 + i, 0, 0);
    add(1, 1, 0, 8'h77, 16, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 8'h00, 15 - i, 0, 0);
    add(1, 1, 0, 8'h5A, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1);
    add(0, 0, 1, 8'h00, 0, 0, 0);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("pop_valid_reset", {31'd0, bus.pop_valid}, 32'd0);
    check_idle(0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) do_step(tbl[i]);

    // Reset with an entry stored and a push press in flight, button held low.
    v.push = 1; v.pop = 0; v.clr = 0; v.data = 8'h3C;
    v.exp_count = 1; v.exp_ovf = 0; v.exp_unf = 0;
    do_step(v);
    @(negedge clk);
    bus.din    = 8'h66;
    bus.push_n = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (100) @(negedge clk);
    check_idle(0, 0, 0);

    // Release, then one long press: exactly one push.
    bus.push_n = 1'b1;
    repeat (10) @(negedge clk);
    bus.din    = 8'hA5;
    bus.push_n = 1'b0;
    model_q.push_back(8'hA5);
    repeat (100) @(negedge clk);
    bus.push_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle(1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
